// File: rtl/input_conditioner.sv
// Turns a raw asynchronous, bouncing input into a clean registered level
// plus one-cycle rise/fall pulses, via a 2-FF synchronizer and a run-length filter.
module input_conditioner #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic qbar,
   output logic rise,
   output logic fall
);

   typedef enum logic [1:0] {
      LOW   = 2'd0,
      CHK_H = 2'd1,
      HIGH  = 2'd2,
      CHK_L = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_q, q_d;
   logic             qbar_q, qbar_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   always_comb begin
      s1_d    = din;
      s2_d    = s1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      qbar_d  = qbar_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         LOW: begin
            if (s2_q) begin
               state_d = CHK_H;
               cnt_d   = ONE;
            end else begin
               cnt_d = '0;
            end
         end
         CHK_H: begin
            if (!s2_q) begin
               state_d = LOW;
               cnt_d   = '0;
            end else if (cnt_q == LAST) begin
               state_d = HIGH;
               cnt_d   = '0;
               q_d     = 1'b1;
               qbar_d  = 1'b0;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         HIGH: begin
            if (!s2_q) begin
               state_d = CHK_L;
               cnt_d   = ONE;
            end else begin
               cnt_d = '0;
            end
         end
         CHK_L: begin
            if (s2_q) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else if (cnt_q == LAST) begin
               state_d = LOW;
               cnt_d   = '0;
               q_d     = 1'b0;
               qbar_d  = 1'b1;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: begin
            state_d = LOW;
            cnt_d   = '0;
         end
      endcase
   end

   // Reset wins over every transition, including an acceptance in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= LOW;
         cnt_q   <= '0;
         q_q     <= 1'b0;
         qbar_q  <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         qbar_q  <= qbar_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign q    = q_q;
   assign qbar = qbar_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a run-length reference model
// pushes expected {q,qbar,rise,fall} per edge; tasks pop and compare.
module tb_input_conditioner;

   localparam int SC = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din = 1'b0;
   logic q, qbar, rise, fall;

   int checks   = 0;
   int failures = 0;

   logic [3:0] sb[$];
   logic [3:0] exp_v;

   logic m_s1 = 1'b0;
   logic m_s2 = 1'b0;
   logic m_q  = 1'b0;
   logic m_rise = 1'b0;
   logic m_fall = 1'b0;
   int   m_run  = 0;

   input_conditioner #(.STABLE_CYCLES(SC), .CNT_W(3)) dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din),
      .q    (q),
      .qbar (qbar),
      .rise (rise),
      .fall (fall)
   );

   always #5 clk = ~clk;

   // Model: count consecutive synchronized samples differing from q.
   task automatic step(input logic d, input logic r);
      din = d;
      rst = r;
      if (r) begin
         m_s1 = 0; m_s2 = 0; m_q = 0;
         m_run = 0; m_rise = 0; m_fall = 0;
      end else begin
         m_rise = 0;
         m_fall = 0;
         if (m_s2 != m_q) begin
            m_run++;
            if (m_run == SC) begin
               m_q    = ~m_q;
               m_rise = m_q;
               m_fall = ~m_q;
               m_run  = 0;
            end
         end else begin
            m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = d;
      end
      sb.push_back({m_q, ~m_q, m_rise, m_fall});
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input logic d, input int n);
      for (int i = 0; i < n; i++) begin
         step(d, 1'b0);
         exp_v = sb.pop_front();
      end
   endtask

   task automatic test_reset();
      int qi;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1);
         exp_v = sb.pop_front();
         checks++;
         if ({q, qbar, rise, fall} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_hold i=%0d got=%b exp=0100",
                     i, {q, qbar, rise, fall});
         end
      end
      qi = -1;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0);
         exp_v = sb.pop_front();
         checks++;
         if ({q, qbar, rise, fall} !== exp_v) begin
            failures++;
            $display("FAIL reset_model i=%0d got=%b exp=%b",
                     i, {q, qbar, rise, fall}, exp_v);
         end
         if (q === 1'b1 && qi < 0) qi = i;
      end
      checks++;
      if (qi != 5) begin
         failures++;
         $display("FAIL reset_release_lat got=%0d exp=5", qi);
      end
   endtask

   task automatic test_rise();
      int qi, nr, nf;
      settle(1'b0, 10);
      qi = -1; nr = 0; nf = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0);
         exp_v = sb.pop_front();
         checks++;
         if ({q, qbar, rise, fall} !== exp_v) begin
            failures++;
            $display("FAIL rise_model i=%0d got=%b exp=%b",
                     i, {q, qbar, rise, fall}, exp_v);
         end
         if (q === 1'b1 && qi < 0) qi = i;
         if (rise === 1'b1) nr++;
         if (fall === 1'b1) nf++;
      end
      checks++;
      if (qi != 5 || nr != 1 || nf != 0) begin
         failures++;
         $display("FAIL rise_lat got=%0d/%0d/%0d exp=5/1/0", qi, nr, nf);
      end
   endtask

   task automatic test_filter();
      int qi, fi, nr;
      settle(1'b0, 10);
      nr = 0;
      for (int i = 0; i < 11; i++) begin
         step((i < 3) ? 1'b1 : 1'b0, 1'b0);
         exp_v = sb.pop_front();
         checks++;
         if ({q, qbar, rise, fall} !== exp_v) begin
            failures++;
            $display("FAIL short_model i=%0d got=%b exp=%b",
                     i, {q, qbar, rise, fall}, exp_v);
         end
         if (rise === 1'b1 || q === 1'b1) nr++;
      end
      checks++;
      if (nr != 0) begin
         failures++;
         $display("FAIL short_reject got=%0d exp=0", nr);
      end
      qi = -1; fi = -1;
      for (int i = 0; i < 14; i++) begin
         step((i < 4) ? 1'b1 : 1'b0, 1'b0);
         exp_v = sb.pop_front();
         checks++;
         if ({q, qbar, rise, fall} !== exp_v) begin
            failures++;
            $display("FAIL exact_model i=%0d got=%b exp=%b",
                     i, {q, qbar, rise, fall}, exp_v);
         end
         if (q === 1'b1 && qi < 0) qi = i;
         if (fall === 1'b1 && fi < 0) fi = i;
      end
      checks++;
      if (qi != 5 || fi != 9) begin
         failures++;
         $display("FAIL exact_accept got=%0d/%0d exp=5/9", qi, fi);
      end
   endtask

   task automatic test_fall();
      int qi, nf, nlow;
      settle(1'b1, 10);
      qi = -1; nf = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0);
         exp_v = sb.pop_front();
         checks++;
         if ({q, qbar, rise, fall} !== exp_v) begin
            failures++;
            $display("FAIL fall_model i=%0d got=%b exp=%b",
                     i, {q, qbar, rise, fall}, exp_v);
         end
         if (q === 1'b0 && qi < 0) qi = i;
         if (fall === 1'b1) nf++;
      end
      checks++;
      if (qi != 5 || nf != 1) begin
         failures++;
         $display("FAIL fall_lat got=%0d/%0d exp=5/1", qi, nf);
      end
      settle(1'b1, 10);
      nf = 0; nlow = 0;
      for (int i = 0; i < 10; i++) begin
         step((i < 2) ? 1'b0 : 1'b1, 1'b0);
         exp_v = sb.pop_front();
         checks++;
         if ({q, qbar, rise, fall} !== exp_v) begin
            failures++;
            $display("FAIL glitch_model i=%0d got=%b exp=%b",
                     i, {q, qbar, rise, fall}, exp_v);
         end
         if (fall === 1'b1) nf++;
         if (q !== 1'b1) nlow++;
      end
      checks++;
      if (nf != 0 || nlow != 0) begin
         failures++;
         $display("FAIL glitch_reject got=%0d/%0d exp=0/0", nf, nlow);
      end
   endtask

   task automatic test_reset_mid();
      int qi, nr;
      settle(1'b0, 10);
      qi = -1; nr = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, (i == 3) ? 1'b1 : 1'b0);
         exp_v = sb.pop_front();
         checks++;
         if ({q, qbar, rise, fall} !== exp_v) begin
            failures++;
            $display("FAIL rstmid_model i=%0d got=%b exp=%b",
                     i, {q, qbar, rise, fall}, exp_v);
         end
         if (q === 1'b1 && qi < 0) qi = i;
         if (rise === 1'b1) nr++;
      end
      checks++;
      if (qi != 9 || nr != 1) begin
         failures++;
         $display("FAIL rstmid_lat got=%0d/%0d exp=9/1", qi, nr);
      end
   endtask

   task automatic test_toggle();
      int np;
      logic q0;
      q0 = m_q;
      np = 0;
      for (int i = 0; i < 20; i++) begin
         step((i % 2) == 0 ? 1'b0 : 1'b1, 1'b0);
         exp_v = sb.pop_front();
         checks++;
         if ({q, qbar, rise, fall} !== exp_v) begin
            failures++;
            $display("FAIL toggle_model i=%0d got=%b exp=%b",
                     i, {q, qbar, rise, fall}, exp_v);
         end
         checks++;
         if (qbar !== ~q || (rise === 1'b1 && fall === 1'b1)) begin
            failures++;
            $display("FAIL toggle_invariant i=%0d got=%b exp=qbar=~q,!(r&f)",
                     i, {q, qbar, rise, fall});
         end
         if (rise === 1'b1 || fall === 1'b1 || q !== q0) np++;
      end
      checks++;
      if (np != 0) begin
         failures++;
         $display("FAIL toggle_quiet got=%0d exp=0", np);
      end
   endtask

   task automatic test_back_to_back();
      int ri, fi;
      settle(1'b0, 10);
      ri = -1; fi = -1;
      for (int i = 0; i < 16; i++) begin
         step((i < 5) ? 1'b1 : 1'b0, 1'b0);
         exp_v = sb.pop_front();
         checks++;
         if ({q, qbar, rise, fall} !== exp_v) begin
            failures++;
            $display("FAIL b2b_model i=%0d got=%b exp=%b",
                     i, {q, qbar, rise, fall}, exp_v);
         end
         if (rise === 1'b1 && ri < 0) ri = i;
         if (fall === 1'b1 && fi < 0) fi = i;
      end
      checks++;
      if (ri != 5 || fi != 10) begin
         failures++;
         $display("FAIL b2b_pulses got=%0d/%0d exp=5/10", ri, fi);
      end
   endtask

   initial begin
      test_reset();
      test_rise();
      test_filter();
      test_fall();
      test_reset_mid();
      test_toggle();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
